q_edge_counter: RTL and testbench
=================================

Q_EDGE_COUNTER -- requirements
Module: q_edge_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each edge counter, legal range 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk; it has priority over every other input.
REQ-004 Q  input  1  flip-flop output being monitored, synchronous to clk.
REQ-005 start  input  1  arms a measurement window.
REQ-006 stop  input  1  closes the measurement window.
REQ-007 clear  input  1  synchronous abort; returns to IDLE and zeroes results.
REQ-008 out_ready  input  1  consumer accepts result when high with out_valid.
REQ-009 rise_cnt  output  WIDTH  count of 0->1 transitions on Q in window.
REQ-010 fall_cnt  output  WIDTH  count of 1->0 transitions on Q in window.
REQ-011 out_valid  output  1  result held stable and offered to consumer.
REQ-012 overflow  output  1  sticky; a counter saturated during the window.
REQ-013 busy  output  1  high exactly while state is COUNT.

Function
REQ-014 Block SHALL register Q each cycle into q_d; rise = Q & ~q_d, fall = ~Q & q_d, evaluated combinationally in the current cycle.
REQ-015 q_d SHALL update every cycle in every state, including during clear.
REQ-016 FSM states: IDLE, COUNT, DONE; all state changes take effect at the rising clk edge.
REQ-017 IDLE: start=1 -> COUNT; rise_cnt, fall_cnt and overflow cleared to 0 on that same edge; edges are never counted while in IDLE.
REQ-018 IDLE: stop alone ignored; start and stop together -> start wins, enter COUNT.
REQ-019 COUNT: each cycle with rise=1 increments rise_cnt by 1; each cycle with fall=1 increments fall_cnt by 1; updated value visible after that edge.
REQ-020 COUNT: stop=1 -> DONE; an edge detected in the stop cycle SHALL still be counted.
REQ-021 COUNT: start ignored; start and stop together -> stop wins.
REQ-022 Saturation: a counter at 2^WIDTH-1 receiving another edge SHALL hold at 2^WIDTH-1 (no wrap) and set overflow=1, which stays 1 until next start, clear, or reset.
REQ-023 DONE: out_valid=1; rise_cnt, fall_cnt and overflow held constant; Q edges ignored.
REQ-024 DONE: out_valid & out_ready in a cycle -> IDLE; out_valid is 0 from the following cycle.
REQ-025 out_valid SHALL not drop without out_ready while in DONE, except on clear or reset.
REQ-026 After returning to IDLE, rise_cnt, fall_cnt and overflow SHALL retain the last result until the next start, clear, or reset.
REQ-027 clear=1 in any state -> IDLE; rise_cnt, fall_cnt and overflow cleared to 0; out_valid is 0 next cycle; clear overrides start, stop and out_ready.
REQ-028 out_ready is ignored outside DONE.

Reset
REQ-029 reset=1 SHALL force state IDLE, q_d=0, rise_cnt=0, fall_cnt=0, overflow=0, out_valid=0, busy=0 after the next rising clk edge.
REQ-030 Reset mid-COUNT or mid-DONE SHALL discard the result without out_valid handshake.

Verification
REQ-031 reset held 2 cycles with Q=1, start=1 -> all outputs 0, busy=0; first cycle after release with Q=1 in IDLE counts nothing.
REQ-032 start pulse, then 3 full Q pulses (1 high, 1 low each, 2 cycles per level), stop -> rise_cnt=3, fall_cnt=3, overflow=0, out_valid=1; out_ready low 2 cycles holds values, then high 1 cycle -> out_valid=0 next cycle, counts retained.
REQ-033 WIDTH=4, start, 16 rising edges, stop -> rise_cnt=15, fall_cnt=15 or 16-saturated=15, overflow=1; next start -> counts 0, overflow=0.
REQ-034 5 Q pulses while IDLE, then start, no edges, stop -> rise_cnt=0, fall_cnt=0; also Q rising in the stop cycle after 2 prior rises -> rise_cnt=3.
REQ-035 start, 2 rises, clear asserted together with stop -> IDLE, rise_cnt=0, fall_cnt=0, out_valid never asserted.
REQ-036 In DONE with out_valid=1, assert reset with out_ready=0 -> out_valid=0, counts 0 after next edge; start+stop in same IDLE cycle -> busy=1.

Source files
------------

// File: rtl/q_edge_counter.sv
// q_edge_counter
//   Counts rising and falling transitions of a monitored flip-flop output Q
//   inside a start/stop measurement window. It then offers the result to a
//   consumer with a valid/ready handshake.
//
// Parameters
//   WIDTH      bit width of each edge counter (legal range 2..16)
//
// Ports
//   clk        sole clock; all state updates on its rising edge
//   reset      synchronous, active-high reset; highest priority
//   Q          monitored signal, synchronous to clk
//   start      arms a measurement window (from IDLE)
//   stop       closes the measurement window (from COUNT)
//   clear      synchronous abort: back to IDLE with zeroed results
//   out_ready  consumer accepts the result while out_valid is high
//   rise_cnt   number of 0->1 transitions seen in the window (saturating)
//   fall_cnt   number of 1->0 transitions seen in the window (saturating)
//   out_valid  result is stable and offered (state DONE)
//   overflow   sticky; a counter saturated during the window
//   busy       high exactly while a window is open (state COUNT)
module q_edge_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Q,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rise_cnt,
    output logic [WIDTH-1:0] fall_cnt,
    output logic             out_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;
    logic   q_d;
    logic   rise;
    logic   fall;

    // Edge detection uses the live Q against last cycle's Q, so an edge is
    // acted on in the same cycle it appears.
    always_comb begin
        rise = Q & ~q_d;
        fall = ~Q & q_d;
    end

    // q_d tracks Q in every state, including during clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_d <= 1'b0;
        end else begin
            q_d <= Q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. clear overrides everything. In IDLE, start wins over
    // stop. In COUNT, stop wins over start.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start)     state_nx = COUNT;
                COUNT:   if (stop)      state_nx = DONE;
                DONE:    if (out_ready) state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        out_valid = (state == DONE);
        busy      = (state == COUNT);
    end

    // Result registers. They are zeroed on reset, on clear, and when a new
    // window opens. They only change while counting. Otherwise they keep the
    // last result through DONE and back into IDLE.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            overflow <= 1'b0;
        end else if (state == COUNT) begin
            // An edge on a counter already at all-ones holds the counter and
            // sets the sticky flag.
            if (rise) begin
                if (rise_cnt == '1) begin
                    overflow <= 1'b1;
                end else begin
                    rise_cnt <= rise_cnt + 1'b1;
                end
            end
            if (fall) begin
                if (fall_cnt == '1) begin
                    overflow <= 1'b1;
                end else begin
                    fall_cnt <= fall_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_q_edge_counter.sv
module tb_q_edge_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset, Q, start, stop, clear, out_ready;
    logic [W-1:0] rise_cnt, fall_cnt;
    logic         out_valid, overflow, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle, 1=window open, 2=result offered
    int m_mode = 0;
    int m_rise = 0;
    int m_fall = 0;
    bit m_ovf  = 0;
    bit m_qd   = 0;

    q_edge_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Q        (Q),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .out_ready(out_ready),
        .rise_cnt (rise_cnt),
        .fall_cnt (fall_cnt),
        .out_valid(out_valid),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, q, st, sp, cl, rdy;
        int er, ef;
        bit eo, ev, eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit q, bit st, bit sp, bit cl, bit rdy,
                                int er, int ef, bit eo, bit ev, bit eb);
        vec_t v;
        v.rst = rst; v.q = q; v.st = st; v.sp = sp; v.cl = cl; v.rdy = rdy;
        v.er = er; v.ef = ef; v.eo = eo; v.ev = ev; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int er, input int ef,
                              input bit eo, input bit ev, input bit eb);
        check({tag, ".rise_cnt"},  int'(rise_cnt),  er);
        check({tag, ".fall_cnt"},  int'(fall_cnt),  ef);
        check({tag, ".overflow"},  int'(overflow),  int'(eo));
        check({tag, ".out_valid"}, int'(out_valid), int'(ev));
        check({tag, ".busy"},      int'(busy),      int'(eb));
    endtask

    // Applies the rules for one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        bit r, f;
        r = Q && !m_qd;
        f = !Q && m_qd;
        if (reset) begin
            m_mode = 0; m_rise = 0; m_fall = 0; m_ovf = 0; m_qd = 0;
        end else begin
            m_qd = Q;
            if (clear) begin
                m_mode = 0; m_rise = 0; m_fall = 0; m_ovf = 0;
            end else if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1; m_rise = 0; m_fall = 0; m_ovf = 0;
                end
            end else if (m_mode == 1) begin
                if (m_rise + int'(r) > MAXV || m_fall + int'(f) > MAXV) m_ovf = 1;
                m_rise = (m_rise + int'(r) > MAXV) ? MAXV : m_rise + int'(r);
                m_fall = (m_fall + int'(f) > MAXV) ? MAXV : m_fall + int'(f);
                if (stop) m_mode = 2;
            end else begin
                if (out_ready) m_mode = 0;
            end
        end
    endtask

    task automatic step(input bit rst, input bit q, input bit st, input bit sp,
                        input bit cl, input bit rdy);
        reset = rst; Q = q; start = st; stop = sp; clear = cl; out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        expect_out("model", m_rise, m_fall, m_ovf, m_mode == 2, m_mode == 1);
    endtask

    initial begin
        reset = 1'b1; Q = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; out_ready = 1'b0;

        // Reset behaviour, then three full pulses and the result handshake
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int p = 1; p <= 3; p++) begin
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, p, p - 1, 0, 0, 1));
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, p, p - 1, 0, 0, 1));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, p, p,     0, 0, 1));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, p, p,     0, 0, 1));
        end
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 3, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].q, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].rdy);
            expect_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ef,
                       tbl[i].eo, tbl[i].ev, tbl[i].eb);
        end

        // Saturation: 16 rises and 16 falls on 4-bit counters
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0, 0);
        expect_out("sat_done", MAXV, MAXV, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        expect_out("sat_idle", MAXV, MAXV, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        expect_out("sat_restart", 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // Edges while idle are not counted
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        expect_out("idle_edges", 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);

        // A rise in the stop cycle still counts
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        expect_out("stop_edge", 3, 2, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1);

        // clear together with stop aborts the window
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        expect_out("pre_clear", 2, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1, 0);
        expect_out("clear_stop", 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_out("clear_after", 0, 0, 0, 0, 0);

        // Reset while a result is offered, then start+stop together in idle
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        expect_out("pre_reset", 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        expect_out("reset_done", 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        expect_out("start_stop", 0, 0, 0, 0, 1);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
